// File: rtl/seq_mult_ctrl.sv
// Shift-and-add multiplier: one W-bit ripple add and one right shift per clock, START/BUSY/DONE handshake.
// Optional macro SEQ_MULT_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are all zero.
module seq_mult_ctrl #(
    parameter int unsigned W = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           START,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           BUSY,
    output logic           DONE,
    output logic [2*W-1:0] P
);

    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFin
    } state_e;

    state_e         state_q;
    logic [W-1:0]   m_q;
    logic [W-1:0]   q_q;
    // ACC[W] is always zero once the step's shift is applied, so only W bits are held.
    logic [W-1:0]   acc_q;
    logic [CW-1:0]  cnt_q;

    logic [W-1:0]   addend;
    logic [W-1:0]   sum;
    logic [W:0]     carry;
    logic [W:0]     add_w;
    logic [W-1:0]   acc_next;
    logic [W-1:0]   q_next;
    logic [2*W-1:0] prod_next;
    logic [2*W-1:0] prod_final;
    logic           early_exit;
    logic           last_step;

    assign addend   = q_q[0] ? m_q : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]     = acc_q[i] ^ addend[i] ^ carry[i];
        assign carry[i+1] = (acc_q[i] & addend[i]) | (carry[i] & (acc_q[i] ^ addend[i]));
    end

    // Carry-out is kept as ADD[W]; the shift moves it into the top of ACC.
    assign add_w     = {carry[W], sum};
    assign acc_next  = add_w[W:1];
    assign q_next    = {add_w[0], q_q[W-1:1]};
    assign prod_next = {acc_next, q_next};

`ifdef SEQ_MULT_EARLY_EXIT_EN
    logic [W-1:0] ones;
    logic [W-1:0] rem_mask;

    // Unconsumed multiplier bits sit below bit W-1-CNT after this step's shift.
    assign ones       = '1;
    assign rem_mask   = ones >> (32'(cnt_q) + 32'd1);
    assign early_exit = (q_next & rem_mask) == '0;
    assign prod_final = prod_next >> (32'(W - 1) - 32'(cnt_q));
`else
    assign early_exit = 1'b0;
    assign prod_final = prod_next;
`endif

    assign last_step = (cnt_q == CW'(W - 1)) || early_exit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            P       <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (START) begin
                        m_q     <= A;
                        q_q     <= B;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        BUSY    <= 1'b1;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q <= acc_next;
                    q_q   <= q_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        P       <= prod_final;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    DONE    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    BUSY    <= 1'b0;
                    DONE    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: expected products and timing are queued at each accepted
// START and retired when DONE pulses. Honours SEQ_MULT_EARLY_EXIT_EN for expected step counts.
module tb_seq_mult_ctrl;

    localparam int unsigned W = 8;

    typedef struct {
        logic [2*W-1:0] prod;
        int             k;
        int             steps;
    } exp_t;

    logic           CLK;
    logic           RST;
    logic           START;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           BUSY;
    logic           DONE;
    logic [2*W-1:0] P;

    exp_t           sb[$];
    int             n_cmp;
    int             n_err;
    int             cyc;
    int             busy_cnt;
    bit             prev_done;
    bit             held_mode;
    bit             have_last;
    int             last_done;
    logic [2*W-1:0] last_p;

    seq_mult_ctrl #(
        .W(W)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .START(START),
        .A    (A),
        .B    (B),
        .BUSY (BUSY),
        .DONE (DONE),
        .P    (P)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int steps_for(input logic [W-1:0] b);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        int s = 1;
        for (int i = 0; i < int'(W); i++) if (b[i]) s = i + 1;
        return s;
`else
        return int'(W);
`endif
    endfunction

    function automatic exp_t mk_exp(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        exp_t e;
        e.prod  = (2*W)'(a) * (2*W)'(b);
        e.k     = k;
        e.steps = steps_for(b);
        return e;
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        A     = a;
        B     = b;
        START = 1'b1;
        @(posedge CLK);
        #1;
        sb.push_back(mk_exp(a, b, cyc));
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(posedge CLK);
            t++;
        end
        #1;
        check("pending_after_wait", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: retires scoreboard entries on DONE and checks handshake timing.
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("done_pulse_width", 64'(DONE), 64'd0);
            check("done_without_op", 64'(DONE && sb.size() == 0), 64'd0);
            if (DONE && sb.size() != 0) begin
                e = sb.pop_front();
                check("product", 64'(P), 64'(e.prod));
                check("done_latency", 64'(cyc - e.k), 64'(e.steps));
                check("busy_cycles", 64'(busy_cnt), 64'(e.steps));
                check("busy_at_done", 64'(BUSY), 64'd0);
                if (held_mode && have_last)
                    check("done_spacing", 64'(cyc - last_done), 64'(e.steps + 2));
                last_done = cyc;
                have_last = 1'b1;
                last_p    = e.prod;
                busy_cnt  = 0;
            end else if (BUSY) begin
                busy_cnt++;
            end
            prev_done = DONE;
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_cmp     = 0;
        n_err     = 0;
        busy_cnt  = 0;
        prev_done = 1'b0;
        held_mode = 1'b0;
        have_last = 1'b0;
        last_done = 0;
        last_p    = '0;
        RST       = 1'b1;
        START     = 1'b0;
        A         = '0;
        B         = '0;

        repeat (2) @(negedge CLK);
        check("reset_busy", 64'(BUSY), 64'd0);
        check("reset_done", 64'(DONE), 64'd0);
        check("reset_p", 64'(P), 64'd0);
        RST = 1'b0;

        start_op(8'h0D, 8'h0B);
        wait_done(40);
        check("p_0d_0b", 64'(P), 64'h008F);

        start_op(8'hFF, 8'hFF);
        wait_done(40);
        check("p_ff_ff", 64'(P), 64'hFE01);
        start_op(8'h00, 8'hA5);
        wait_done(40);
        check("p_00_a5", 64'(P), 64'h0000);

        // START during CALC must be ignored.
        start_op(8'h12, 8'h34);
        repeat (2) @(posedge CLK);
        #1;
        A     = 8'h99;
        B     = 8'h99;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_done(40);
        repeat (W + 4) @(posedge CLK);
        #1;
        check("p_12_34_hold", 64'(P), 64'h03A8);

        // Asynchronous reset in the middle of the fourth CALC cycle.
        start_op(8'h0F, 8'h0F);
        repeat (3) @(posedge CLK);
        #3;
        RST = 1'b1;
        sb.delete();
        #1;
        check("abort_busy", 64'(BUSY), 64'd0);
        check("abort_done", 64'(DONE), 64'd0);
        check("abort_p", 64'(P), 64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (W + 6) @(posedge CLK);
        #1;
        check("abort_p_idle", 64'(P), 64'd0);
        start_op(8'h03, 8'h05);
        wait_done(40);
        check("p_03_05", 64'(P), 64'h000F);

        // Early-exit vectors; full-length in the default build.
        start_op(8'h07, 8'h01);
        wait_done(40);
        start_op(8'h07, 8'h80);
        wait_done(40);
        check("p_07_80", 64'(P), 64'h0380);

        // START held high: each acceptance follows the previous one by steps+2 edges.
        held_mode = 1'b1;
        have_last = 1'b0;
        @(negedge CLK);
        ra    = W'($urandom);
        rb    = W'($urandom);
        A     = ra;
        B     = rb;
        START = 1'b1;
        @(posedge CLK);
        for (int i = 0; i < 200; i++) begin
            exp_t e;
            #1;
            e = mk_exp(ra, rb, cyc);
            sb.push_back(e);
            if (i == 199) begin
                START = 1'b0;
            end else begin
                ra = W'($urandom);
                rb = W'($urandom);
                A  = ra;
                B  = rb;
                repeat (e.steps + 2) @(posedge CLK);
            end
        end
        wait_done(60);
        held_mode = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("p_final_hold", 64'(P), 64'(last_p));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
